// File: rtl/ysyx_22051145_mdu_ctrl.sv
// ysyx_22051145_mdu_ctrl: multi-cycle RV64M mul/div sequencer for the EXU.
// Shared 128-bit accumulator: radix-2 shift-add multiply, restoring divide.
// Build option: define YSYX_22051145_MDU_FAST_MUL_EN for a single-cycle
// combinational multiply (IDLE->DONE); divide stays iterative.
//
// state | meaning
// IDLE  | waiting for a request, in_ready = 1
// CALC  | one shift/add or shift/subtract iteration per cycle
// DONE  | result held, out_valid = 1 until out_ready
module ysyx_22051145_mdu_ctrl #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t            state_q, state_d;
  logic [6:0]        cnt_q;
  logic [3:0]        op_q;
  logic              nq_q, nr_q;
  logic [2*XLEN-1:0] acc_q, acc_nxt;
  logic [XLEN-1:0]   dvs_q, result_q;

  // Turns the final accumulator into the architectural result. W multiplies
  // leave their 32-bit product in acc[63:32] after 32 iterations.
  function automatic logic [XLEN-1:0] finalize(input logic [2*XLEN-1:0] a,
                                               input logic [3:0] o,
                                               input logic nq, input logic nr);
    logic [2*XLEN-1:0] p;
    logic [XLEN-1:0]   q, r, v;
    p = nq ? -a : a;
    q = o[3] ? {32'b0, a[31:0]} : a[63:0];
    r = a[127:64];
    v = o[1] ? (nr ? -r : r) : (nq ? -q : q);
    if (o[2])                 finalize = o[3] ? {{32{v[31]}}, v[31:0]} : v;
    else if (o[3])            finalize = {{32{a[63]}}, a[63:32]};
    else if (o[1:0] == 2'b00) finalize = p[63:0];
    else                      finalize = p[127:64];
  endfunction

  // Request decode on the live inputs (only meaningful in IDLE)
  logic            is_w, is_div, is_rem, dv_sgn, reserved, is_mul;
  logic            mul_s1, mul_s2, m1_neg, m2_neg, a_neg, b_neg;
  logic            div_zero, div_ovf, special, fast_go, go_done, fire;
  logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, m1_mag, m2_mag, rem_dz;
  logic [XLEN-1:0] spec_res, fast_res;

  assign is_w     = op[3];
  assign is_div   = op[2];
  assign is_rem   = op[1];
  assign dv_sgn   = ~op[0];
  assign reserved = op[3] & ~op[2] & (op[1:0] != 2'b00);
  assign is_mul   = ~op[2] & (~op[3] | (op[1:0] == 2'b00));
  assign mul_s1   = (op == 4'd1) | (op == 4'd2);
  assign mul_s2   = (op == 4'd1);

  assign a_ext  = is_w ? {{32{dv_sgn & op1[31]}}, op1[31:0]} : op1;
  assign b_ext  = is_w ? {{32{dv_sgn & op2[31]}}, op2[31:0]} : op2;
  assign a_neg  = dv_sgn & a_ext[63];
  assign b_neg  = dv_sgn & b_ext[63];
  assign a_mag  = a_neg ? -a_ext : a_ext;
  assign b_mag  = b_neg ? -b_ext : b_ext;
  assign rem_dz = is_w ? {{32{op1[31]}}, op1[31:0]} : op1;

  // MULW only needs the low 32 product bits, so its operands go in unsigned
  assign m1_neg = mul_s1 & op1[63];
  assign m2_neg = mul_s2 & op2[63];
  assign m1_mag = (op == 4'd8) ? {32'b0, op1[31:0]} : (m1_neg ? -op1 : op1);
  assign m2_mag = (op == 4'd8) ? {32'b0, op2[31:0]} : (m2_neg ? -op2 : op2);

  assign div_zero = (b_ext == '0);
  assign div_ovf  = dv_sgn & (b_ext == '1) &
                    (is_w ? (op1[31:0] == 32'h8000_0000) : (op1 == {1'b1, 63'b0}));
  assign special  = reserved | (is_div & (div_zero | div_ovf));

  // Results that skip the iterative datapath
  always_comb begin
    spec_res = '0;
    if (is_div && div_zero)     spec_res = is_rem ? rem_dz : '1;
    else if (is_div && div_ovf) spec_res = is_rem ? '0 : a_ext;
  end

`ifdef YSYX_22051145_MDU_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_prod;
  assign fast_prod = {{XLEN{1'b0}}, m1_mag} * {{XLEN{1'b0}}, m2_mag};
  assign fast_go   = is_mul;
  assign fast_res  = finalize((op == 4'd8) ? (fast_prod << 32) : fast_prod,
                              op, m1_neg ^ m2_neg, 1'b0);
`else
  assign fast_go  = 1'b0;
  assign fast_res = '0;
`endif

  assign go_done = special | fast_go;
  assign fire    = in_valid & in_ready & ~flush;

  // One datapath iteration: add-and-shift-right or trial-subtract-and-shift-left
  logic [XLEN:0] sum, trial;
  always_comb begin
    sum   = {1'b0, acc_q[127:64]} + {1'b0, dvs_q};
    trial = acc_q[127:63] - {1'b0, dvs_q};
    if (!op_q[2]) acc_nxt = acc_q[0] ? {sum, acc_q[63:1]} : {1'b0, acc_q[127:1]};
    else          acc_nxt = trial[64] ? {acc_q[126:0], 1'b0}
                                      : {trial[63:0], acc_q[62:0], 1'b1};
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; flush wins over everything else
  always_comb begin
    state_d = state_q;
    if (flush) state_d = IDLE;
    else begin
      case (state_q)
        IDLE:    if (fire) state_d = go_done ? DONE : CALC;
        CALC:    if (cnt_q == 7'd1) state_d = DONE;
        DONE:    if (out_ready) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Handshake outputs decoded from state
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state_q)
      IDLE:    begin in_ready = 1'b1; busy = 1'b0; end
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  // Operand capture, iteration and result register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      op_q     <= '0;
      nq_q     <= 1'b0;
      nr_q     <= 1'b0;
      acc_q    <= '0;
      dvs_q    <= '0;
      result_q <= '0;
    end else if (!flush) begin
      case (state_q)
        IDLE: if (fire) begin
          op_q <= op;
          if (go_done) result_q <= fast_go ? fast_res : spec_res;
          else begin
            cnt_q <= is_w ? 7'd32 : 7'd64;
            if (is_div) begin
              acc_q <= is_w ? {64'b0, a_mag[31:0], 32'b0} : {64'b0, a_mag};
              dvs_q <= b_mag;
              nq_q  <= a_neg ^ b_neg;
              nr_q  <= a_neg;
            end else begin
              acc_q <= {64'b0, m2_mag};
              dvs_q <= m1_mag;
              nq_q  <= m1_neg ^ m2_neg;
              nr_q  <= 1'b0;
            end
          end
        end
        CALC: begin
          acc_q <= acc_nxt;
          cnt_q <= cnt_q - 7'd1;
          if (cnt_q == 7'd1) result_q <= finalize(acc_nxt, op_q, nq_q, nr_q);
        end
        default: ;
      endcase
    end
  end

  assign result = result_q;

endmodule

// File: doc/ysyx_22051145_mdu_ctrl.md
# ysyx_22051145_mdu_ctrl

Multi-cycle sequencer for the RV64M group (`DECINFO_GRP_MULDIV`) of the execute stage. It accepts one mul/div operation through a valid/ready handshake, iterates a shared shift/add/subtract datapath for a fixed number of cycles, and returns a 64-bit result. The core stalls EXU writeback until `out_valid`. Integer ALU operations are not handled here and bypass the block.

## Interface
Parameters:
- `XLEN`, 64: operand and result width; fixed at 64 for RV64.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  synchronous reset, active-high.
- `in_valid`  in  1  operation request.
- `in_ready`  out  1  block can accept a request; 1 only in IDLE.
- `op`  in  4  operation code:
  - 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU
  - 4 DIV, 5 DIVU, 6 REM, 7 REMU
  - 8 MULW
  - 12 DIVW, 13 DIVUW, 14 REMW, 15 REMUW
  - 9, 10, 11 reserved
- `op1`  in  64  rs1 value.
- `op2`  in  64  rs2 value.
- `flush`  in  1  abort any in-flight operation; pipeline redirect.
- `out_valid`  out  1  `result` is valid.
- `out_ready`  in  1  consumer accepts the result.
- `result`  out  64  registered result.
- `busy`  out  1  state is not IDLE.

## Operation
States: IDLE, CALC, DONE.
- **IDLE:**
  - `in_valid & in_ready & ~flush` latches `op`, `op1`, `op2`.
  - Goes to DONE for special cases; otherwise to CALC with iteration counter = N.
  - N = 64 for 64-bit ops. N = 32 for W ops, which use `op1[31:0]` and `op2[31:0]` sign- or zero-extended per op.
- **CALC:**
  - One iteration per cycle; counter decrements; DONE when counter reaches 0.
  - Multiply: radix-2 shift-add into a 128-bit accumulator. Signed operands are handled by magnitude plus sign correction.
  - MUL / MULW take the low bits. MULH, MULHSU, MULHU take `acc[127:64]`.
  - Divide: restoring, one quotient bit per cycle on operand magnitudes. Quotient sign = sign(op1) ^ sign(op2). Remainder sign = sign(op1).
- **DONE:**
  - `out_valid` = 1; `result` is held stable.
  - `out_valid & out_ready` returns to IDLE.
- **W ops:** result = sign-extension of the 32-bit result bit 31.
- **Special cases** (go straight to DONE, no CALC):
  - Divide by zero: quotient = all ones (W: `64'hFFFFFFFF_FFFFFFFF`); remainder = op1 (W: sext(op1[31:0])).
  - Signed overflow: DIV of `0x8000_0000_0000_0000` by -1 gives quotient = op1, remainder = 0. DIVW of `0x8000_0000` by -1 gives quotient = `0xFFFFFFFF_80000000`, remainder = 0.
  - Reserved op: result = 0.
- **flush:**
  - In any state, next state = IDLE, `out_valid` = 0, and the in-flight result is discarded.
  - A request presented in the same cycle as `flush` is not accepted.
  - `flush` has priority over `out_ready` and `in_valid`.
- **Inputs:** `op1`/`op2` changing after acceptance have no effect.

## Timing
- Reset: state = IDLE, `in_ready` = 1, `out_valid` = 0, `busy` = 0, `result` = 0, counter = 0, accumulators = 0.
- Accept on the edge ending cycle T. CALC occupies T+1 … T+N. `out_valid` = 1 from T+N+1.
  - Latency: 65 cycles for 64-bit ops, 33 cycles for W ops.
- Special case: `out_valid` = 1 at T+1.
- Back-to-back: the earliest next accept is the cycle after the `out_valid & out_ready` handshake, since `in_ready` rises then.
- `out_ready` held low: DONE persists indefinitely with `result` unchanged.
- `rst` mid-CALC: the operation is lost; all outputs return to reset values on the next edge.

## Configuration
- `YSYX_22051145_MDU_FAST_MUL_EN`
  - **Defined:** multiply ops (0–3, 8) compute the 128-bit product with a single combinational multiplier. They go IDLE→DONE, so `out_valid` is asserted at T+1. Divide is unchanged.
  - **Undefined:** multiply uses the iterative path with 64/32-cycle latency as above.
  - Results are bit-identical in both builds.

## Test plan
- MUL op1 = 7, op2 = -3 (`0xFFFF_FFFF_FFFF_FFFD`) → `result` = `0xFFFF_FFFF_FFFF_FFEB` at T+65 (T+1 with FAST_MUL); `out_valid` holds while `out_ready` = 0 for 5 cycles.
- MULHU op1 = op2 = `0xFFFF_FFFF_FFFF_FFFF` → `0xFFFF_FFFF_FFFF_FFFE`. MULH with the same operands → 0.
- DIV -7 / 2 → `0xFFFF_FFFF_FFFF_FFFD`. REM -7 / 2 → `0xFFFF_FFFF_FFFF_FFFF`. DIVUW `0x1_0000_000A` / 3 → 3.
- DIVU by 0 → `0xFFFF_FFFF_FFFF_FFFF` at T+1. REM `0x8000_0000_0000_0000` / -1 → 0 at T+1. REMW 5 / 0 → 5.
- Assert `flush` at CALC cycle 10 → `busy` = 0 and `in_ready` = 1 next cycle. No `out_valid`. A following MULW `0x7FFF_FFFF` × 2 returns `0xFFFF_FFFF_FFFF_FFFE`.
- Assert `rst` mid-CALC → all outputs at reset values next cycle. `in_valid` with `flush` in the same cycle → not accepted, `busy` stays 0.
